// File: rtl/mod_counter_7seg_pkg.sv
// Shared constants for the counter/display family: hex segment table,
// blank pattern and a polarity helper used by every segment driver.
package counter_pkg;

  // Active-high segment patterns {a,b,c,d,e,f,g}, bit 6 = a, for hex 0..F.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // All segments off (active-high sense).
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Convert an active-high pattern to the board's pin polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
    logic [6:0] r_out;
    if (active_low) begin
      r_out = ~seg;
    end else begin
      r_out = seg;
    end
    return r_out;
  endfunction

endpackage

// File: rtl/mod_counter_7seg_seg7_decoder.sv
// Single-digit hex to 7-segment decoder. Purely combinational so that a
// multi-digit scanner can share one instance across time-multiplexed digits.
module seg7_decoder
  import counter_pkg::*;
(
  input  logic [3:0] iNibble,
  input  logic       iActiveLow,
  output logic [6:0] oSeg
);

  logic [6:0] w_seg_hi;

  // Table lookup in active-high sense, then apply the pin polarity.
  always_comb begin
    w_seg_hi = SEG_BLANK;
    w_seg_hi = SEG_HEX[iNibble];
    oSeg     = seg_polarity(w_seg_hi, iActiveLow);
  end

endmodule

// File: rtl/mod_counter_7seg.sv
// Modulo-N up/down counter with enable prescaler, synchronous clamped load
// and a registered terminal-count pulse, driving one hex 7-segment digit.
module mod_counter_7seg
  import counter_pkg::*;
#(
  parameter int WIDTH          = 3,
  parameter int MODULO         = 8,
  parameter int DIV            = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oQ,
  output logic             oTC,
  output logic [6:0]       oDisplay
);

  // Prescaler needs at least one bit even when DIV=1 (it then stays at 0).
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH is representable for the clamp test.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

`ifndef SYNTHESIS
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("mod_counter_7seg: WIDTH must be in 1..8");
  end
  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("mod_counter_7seg: MODULO must be in 2..2**WIDTH");
  end
  if (DIV < 1) begin : g_bad_div
    $error("mod_counter_7seg: DIV must be >= 1");
  end
`endif

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_pre;
  logic             r_tc;

  logic             w_tick;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_q_nxt;
  logic [PW-1:0]    w_pre_nxt;
  logic             w_tc_nxt;
  logic [3:0]       w_nibble;

  // A count tick happens on the last enabled prescaler cycle.
  assign w_tick = iEn && (r_pre == PRE_LAST);

  // Out-of-range load values collapse to 0 so oQ can never leave 0..MODULO-1.
  assign w_load_val = ({1'b0, iData} < MOD_EXT) ? iData : '0;

  // Next-state for count, prescaler and terminal-count pulse; load wins over tick.
  always_comb begin
    w_q_nxt   = r_q;
    w_pre_nxt = r_pre;
    w_tc_nxt  = 1'b0;
    if (iLoad) begin
      w_q_nxt   = w_load_val;
      w_pre_nxt = '0;
    end else begin
      if (iEn) begin
        if (r_pre == PRE_LAST) begin
          w_pre_nxt = '0;
        end else begin
          w_pre_nxt = r_pre + PW'(1);
        end
      end else begin
        w_pre_nxt = r_pre;
      end

      if (w_tick) begin
        if (iUp) begin
          if (r_q == Q_LAST) begin
            w_q_nxt  = '0;
            w_tc_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q + WIDTH'(1);
          end
        end else begin
          if (r_q == '0) begin
            w_q_nxt  = Q_LAST;
            w_tc_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q - WIDTH'(1);
          end
        end
      end else begin
        w_q_nxt = r_q;
      end
    end
  end

  // State registers; reset is asynchronous so the display clears immediately.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_pre <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_pre <= w_pre_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  // Low nibble of the count selects the glyph (zero-extended for narrow counts).
  assign w_nibble = 4'(r_q);

  seg7_decoder u_dec (
    .iNibble    (w_nibble),
    .iActiveLow (SEG_ACTIVE_LOW),
    .oSeg       (oDisplay)
  );

  assign oQ  = r_q;
  assign oTC = r_tc;

endmodule

// File: tb/tb_mod_counter_7seg.sv
// Bench for mod_counter_7seg: four parameter builds share one stimulus stream
// and are compared against an arithmetic reference model every cycle.
module tb_mod_counter_7seg;

  localparam int NI = 4;
  // Builds: 0 default, 1 decimal, 2 DIV=4, 3 decimal DIV=3 common-anode.
  localparam int P_W  [NI] = '{3, 4, 3, 4};
  localparam int P_M  [NI] = '{8, 10, 8, 10};
  localparam int P_D  [NI] = '{1, 1, 4, 3};
  localparam int P_AL [NI] = '{0, 0, 0, 1};

  logic       CLK;
  logic       rst_n;
  logic       drv_en;
  logic       drv_up;
  logic       drv_ld;
  logic [3:0] drv_data;

  logic [2:0] q0;
  logic [3:0] q1;
  logic [2:0] q2;
  logic [3:0] q3;
  logic       tc0, tc1, tc2, tc3;
  logic [6:0] d0, d1, d2, d3;

  int n_checks = 0;
  int n_errors = 0;

  mod_counter_7seg #(.WIDTH(3), .MODULO(8), .DIV(1), .SEG_ACTIVE_LOW(1'b0)) u_d (
    .CLK(CLK), .rst_n(rst_n), .iEn(drv_en), .iUp(drv_up), .iLoad(drv_ld),
    .iData(drv_data[2:0]), .oQ(q0), .oTC(tc0), .oDisplay(d0));
  mod_counter_7seg #(.WIDTH(4), .MODULO(10), .DIV(1), .SEG_ACTIVE_LOW(1'b0)) u_m10 (
    .CLK(CLK), .rst_n(rst_n), .iEn(drv_en), .iUp(drv_up), .iLoad(drv_ld),
    .iData(drv_data), .oQ(q1), .oTC(tc1), .oDisplay(d1));
  mod_counter_7seg #(.WIDTH(3), .MODULO(8), .DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_p4 (
    .CLK(CLK), .rst_n(rst_n), .iEn(drv_en), .iUp(drv_up), .iLoad(drv_ld),
    .iData(drv_data[2:0]), .oQ(q2), .oTC(tc2), .oDisplay(d2));
  mod_counter_7seg #(.WIDTH(4), .MODULO(10), .DIV(3), .SEG_ACTIVE_LOW(1'b1)) u_p3 (
    .CLK(CLK), .rst_n(rst_n), .iEn(drv_en), .iUp(drv_up), .iLoad(drv_ld),
    .iData(drv_data), .oQ(q3), .oTC(tc3), .oDisplay(d3));

  logic [3:0] a_q  [NI];
  logic       a_tc [NI];
  logic [6:0] a_dp [NI];
  assign a_q[0] = {1'b0, q0};
  assign a_q[1] = q1;
  assign a_q[2] = {1'b0, q2};
  assign a_q[3] = q3;
  assign a_tc[0] = tc0;
  assign a_tc[1] = tc1;
  assign a_tc[2] = tc2;
  assign a_tc[3] = tc3;
  assign a_dp[0] = d0;
  assign a_dp[1] = d1;
  assign a_dp[2] = d2;
  assign a_dp[3] = d3;

  // 20 ns clock; negedges at 10,30,50... so the 50 ns reset release is off-edge.
  initial begin
    CLK = 1'b1;
    forever #10 CLK = ~CLK;
  end

  // Reference model: modular arithmetic on integers.
  int m_q  [NI];
  int m_p  [NI];
  int m_tc [NI];

  // Model update on each edge, cleared asynchronously like the hardware.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_q[i]  <= 0;
        m_p[i]  <= 0;
        m_tc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (drv_ld) begin
          m_q[i]  <= ((int'(drv_data) % (1 << P_W[i])) < P_M[i]) ? (int'(drv_data) % (1 << P_W[i])) : 0;
          m_p[i]  <= 0;
          m_tc[i] <= 0;
        end else begin
          if (drv_en) m_p[i] <= (m_p[i] + 1) % P_D[i];
          if (drv_en && (m_p[i] == P_D[i] - 1)) begin
            if (drv_up) begin
              m_q[i]  <= (m_q[i] + 1) % P_M[i];
              m_tc[i] <= (m_q[i] == P_M[i] - 1) ? 1 : 0;
            end else begin
              m_q[i]  <= (m_q[i] + P_M[i] - 1) % P_M[i];
              m_tc[i] <= (m_q[i] == 0) ? 1 : 0;
            end
          end else begin
            m_tc[i] <= 0;
          end
        end
      end
    end
  end

  function automatic logic [6:0] hex_seg(input int n);
    case (n)
      0: return 7'h7E;   1: return 7'h30;   2: return 7'h6D;   3: return 7'h79;
      4: return 7'h33;   5: return 7'h5B;   6: return 7'h5F;   7: return 7'h70;
      8: return 7'h7F;   9: return 7'h7B;  10: return 7'h77;  11: return 7'h1F;
      12: return 7'h4E; 13: return 7'h3D;  14: return 7'h4F;  15: return 7'h47;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [6:0] e_dp;
    for (int i = 0; i < NI; i++) begin
      e_dp = hex_seg(m_q[i] % 16);
      if (P_AL[i] != 0) e_dp = ~e_dp;
      check($sformatf("model_q[%0d]", i), int'(a_q[i]), m_q[i]);
      check($sformatf("model_tc[%0d]", i), int'(a_tc[i]), m_tc[i]);
      check($sformatf("model_disp[%0d]", i), int'(a_dp[i]), int'(e_dp));
    end
  endtask

  // Drive one cycle of inputs at the negedge, sample at the following negedge.
  task automatic cyc(input logic en, input logic up, input logic ld, input logic [3:0] data);
    drv_en   = en;
    drv_up   = up;
    drv_ld   = ld;
    drv_data = data;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] data;
    int         q_d;
    int         tc_d;
    int         q_m;
    int         tc_m;
  } vec_t;

  vec_t tbl [21];

  initial begin
    // en up ld data | default q,tc | decimal q,tc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 0, 1, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  2, 0, 2, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd0,  3, 0, 3, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'd0,  4, 0, 4, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  5, 0, 5, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd0,  6, 0, 6, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  7, 0, 7, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'd0,  0, 1, 8, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 8, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  7, 1, 7, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  6, 0, 6, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'd5,  5, 0, 5, 0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 4'd12, 4, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 4'd0,  3, 0, 9, 1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 4'd0,  2, 0, 8, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 4'd3,  3, 0, 3, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 4'd0,  4, 0, 4, 0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 4'd0,  3, 0, 3, 0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 4'd0,  2, 0, 2, 0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 4'd0,  1, 0, 1, 0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 4'd9,  1, 0, 1, 0};

    rst_n    = 1'b0;
    drv_en   = 1'b1;
    drv_up   = 1'b1;
    drv_ld   = 1'b0;
    drv_data = 4'd0;

    // Reset values, sampled while reset is still held.
    #50;
    check("rst_q", int'(q0), 0);
    check("rst_tc", int'(tc0), 0);
    check("rst_disp", int'(d0), int'(7'b1111110));
    check("rst_disp_al", int'(d3), int'(7'b0000001));
    check_model();
    rst_n = 1'b1;

    // Table-driven vectors on the DIV=1 builds.
    for (int k = 0; k < 21; k++) begin
      cyc(tbl[k].en, tbl[k].up, tbl[k].ld, tbl[k].data);
      check($sformatf("tbl%0d_q_d", k), int'(q0), tbl[k].q_d);
      check($sformatf("tbl%0d_tc_d", k), int'(tc0), tbl[k].tc_d);
      check($sformatf("tbl%0d_q_m", k), int'(q1), tbl[k].q_m);
      check($sformatf("tbl%0d_tc_m", k), int'(tc1), tbl[k].tc_m);
      check_model();
    end
    check("disp_nine", int'(d1), int'(hex_seg(1)));

    // Prescaler DIV=4 with an enable gap mid-prescale.
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'd0);
      check("div4_pre", int'(q2), 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    check("div4_tick1", int'(q2), 1);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'd0);
      check("div4_hold", int'(q2), 1);
      check_model();
    end
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    check("div4_resume_a", int'(q2), 1);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    check("div4_resume_b", int'(q2), 2);
    check_model();

    // Decimal down-count from reset shows 9 after the wrap.
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    check("dn_q9", int'(q1), 9);
    check("dn_disp9", int'(d1), int'(7'b1111011));
    check("dn_tc", int'(tc1), 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    check("dn_q8", int'(q1), 8);
    check("dn_tc_low", int'(tc1), 0);

    // Asynchronous reset between edges, DIV=3 build parked at 6 mid-prescale.
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) cyc(1'b1, 1'b1, 1'b0, 4'd0);
    check("ar_q6", int'(q3), 6);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    #5;
    rst_n = 1'b0;
    #1;
    check("ar_q0", int'(q3), 0);
    check("ar_tc0", int'(tc3), 0);
    check("ar_disp_al", int'(d3), int'(7'b0000001));
    check_model();
    @(negedge CLK);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    check("ar_first_wait", int'(q3), 0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    check("ar_first_tick", int'(q3), 1);

    // Randomised stream against the model on every build.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
